fir_job_scheduler: RTL

Sequencing controller between the two SPI slaves and the FIR filter core. It queues received sample packets and issues filter start pulses. It gates coefficient-load sessions so coefficient writes never overlap a running computation. It generates the result-latch and TX-shift strobes for the output double buffer, and reports overruns and hung computations.

---
 rtl/fir_job_scheduler_if.sv | 60 ++++++
 rtl/fir_job_scheduler.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fir_job_scheduler_if.sv
// Handshake bundle between the host-side SPI/filter glue and fir_job_scheduler.
// The scheduler sits on the slave modport; the driving side uses master.
interface fir_job_scheduler_if #(
    parameter int unsigned DROP_CNT_WIDTH = 8
) ();
    // Requests and events toward the scheduler
    logic                      pktReceivedIn;
    logic                      coefLoadIn;
    logic                      coefWriteIn;
    logic                      firDoneIn;
    logic                      clearIn;

    // Strobes, levels and status from the scheduler
    logic                      firStartOut;
    logic                      firLoadOut;
    logic                      firWriteOut;
    logic                      resultLatchOut;
    logic                      txShiftOut;
    logic                      overrunOut;
    logic                      timeoutOut;
    logic                      coefErrOut;
    logic [DROP_CNT_WIDTH-1:0] dropCntOut;
    logic                      busyOut;

    modport slave (
        input  pktReceivedIn,
        input  coefLoadIn,
        input  coefWriteIn,
        input  firDoneIn,
        input  clearIn,
        output firStartOut,
        output firLoadOut,
        output firWriteOut,
        output resultLatchOut,
        output txShiftOut,
        output overrunOut,
        output timeoutOut,
        output coefErrOut,
        output dropCntOut,
        output busyOut
    );

    modport master (
        output pktReceivedIn,
        output coefLoadIn,
        output coefWriteIn,
        output firDoneIn,
        output clearIn,
        input  firStartOut,
        input  firLoadOut,
        input  firWriteOut,
        input  resultLatchOut,
        input  txShiftOut,
        input  overrunOut,
        input  timeoutOut,
        input  coefErrOut,
        input  dropCntOut,
        input  busyOut
    );
endinterface

// File: rtl/fir_job_scheduler.sv
// fir_job_scheduler: queues one sample packet, starts the FIR core, keeps
// coefficient-load sessions away from running computations, drives the
// output double-buffer strobes and reports overruns, aborts and bad writes.
module fir_job_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned DROP_CNT_WIDTH = 8
) (
    input  logic               clkIn,
    input  logic               resetIn,
    fir_job_scheduler_if.slave bus
);
    localparam int unsigned RUN_CNT_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [RUN_CNT_WIDTH-1:0]  RUN_CNT_LAST = RUN_CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        COEF = 2'd2
    } state_t;

    state_t                   state;
    state_t                   stateNext;
    logic [RUN_CNT_WIDTH-1:0] runCnt;
    logic [RUN_CNT_WIDTH-1:0] runCntNext;
    logic                     pending;
    logic                     pendingNext;

    logic                     startNow;
    logic                     latchNow;
    logic                     abortNow;
    logic                     dropNow;
    logic                     writeFwd;
    logic                     writeRej;

    // State, run counter and pending-packet registers
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            state   <= IDLE;
            runCnt  <= '0;
            pending <= 1'b0;
        end else begin
            state   <= stateNext;
            runCnt  <= runCntNext;
            pending <= pendingNext;
        end
    end

    // Next-state decode: coefficient sessions beat pending packets in IDLE;
    // in RUN a done on the expiry cycle takes precedence over the abort
    always_comb begin
        stateNext  = state;
        runCntNext = runCnt;
        startNow   = 1'b0;
        latchNow   = 1'b0;
        abortNow   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.coefLoadIn) begin
                    stateNext = COEF;
                end else if (pending) begin
                    startNow   = 1'b1;
                    runCntNext = '0;
                    stateNext  = RUN;
                end
            end
            RUN: begin
                if (bus.firDoneIn) begin
                    latchNow  = 1'b1;
                    stateNext = IDLE;
                end else if (runCnt == RUN_CNT_LAST) begin
                    abortNow  = 1'b1;
                    stateNext = IDLE;
                end else begin
                    runCntNext = runCnt + RUN_CNT_WIDTH'(1);
                end
            end
            COEF: begin
                if (!bus.coefLoadIn) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // One-deep packet queue: an arrival in the consume cycle simply refills it,
    // an arrival while it is still occupied is a drop
    always_comb begin
        dropNow     = bus.pktReceivedIn & pending & ~startNow;
        pendingNext = bus.pktReceivedIn | (pending & ~startNow);
    end

    // Coefficient writes pass only inside a load session
    always_comb begin
        writeFwd = bus.coefWriteIn & (state == COEF);
        writeRej = bus.coefWriteIn & (state != COEF);
    end

    // Registered strobes and levels toward the filter and output buffer
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            bus.firStartOut    <= 1'b0;
            bus.resultLatchOut <= 1'b0;
            bus.txShiftOut     <= 1'b0;
            bus.firWriteOut    <= 1'b0;
            bus.firLoadOut     <= 1'b0;
            bus.busyOut        <= 1'b0;
        end else begin
            bus.firStartOut    <= startNow;
            bus.resultLatchOut <= latchNow;
            bus.txShiftOut     <= bus.pktReceivedIn;
            bus.firWriteOut    <= writeFwd;
            bus.firLoadOut     <= (stateNext == COEF);
            bus.busyOut        <= (state != IDLE) || pending;
        end
    end

    // Sticky error flags; a set event in the clear cycle wins
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            bus.overrunOut <= 1'b0;
            bus.timeoutOut <= 1'b0;
            bus.coefErrOut <= 1'b0;
        end else begin
            if (dropNow) begin
                bus.overrunOut <= 1'b1;
            end else if (bus.clearIn) begin
                bus.overrunOut <= 1'b0;
            end
            if (abortNow) begin
                bus.timeoutOut <= 1'b1;
            end else if (bus.clearIn) begin
                bus.timeoutOut <= 1'b0;
            end
            if (writeRej) begin
                bus.coefErrOut <= 1'b1;
            end else if (bus.clearIn) begin
                bus.coefErrOut <= 1'b0;
            end
        end
    end

    // Saturating dropped-packet counter; clear with a simultaneous drop reads 1
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            bus.dropCntOut <= '0;
        end else if (bus.clearIn) begin
            bus.dropCntOut <= dropNow ? DROP_CNT_WIDTH'(1) : '0;
        end else if (dropNow && (bus.dropCntOut != DROP_CNT_MAX)) begin
            bus.dropCntOut <= bus.dropCntOut + DROP_CNT_WIDTH'(1);
        end
    end

endmodule
